// File: rtl/rtc_save_sequencer_if.sv
// Save-file bridge <-> RTC sequencer <-> mapper signal bundle.
// slave: sequencer side; master: bridge/mapper/testbench side.
interface rtc_save_sequencer_if;
  logic        ld_start;
  logic        ld_abort;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_error;
  logic        bk_rtc_wr;
  logic [16:0] bk_addr;
  logic [15:0] bk_data;
  logic        sv_req;
  logic        rtc_inuse;
  logic [31:0] rtc_timestamp;
  logic [47:0] rtc_savedtime;
  logic        sv_valid;
  logic [15:0] sv_data;
  logic        sv_ready;
  logic        sv_done;
  logic        sv_skipped;
  logic        busy;

  modport slave (
    input  ld_start, ld_abort, ld_valid, ld_data,
    input  sv_req, rtc_inuse, rtc_timestamp,
    input  rtc_savedtime, sv_ready,
    output ld_ready, ld_done, ld_error,
    output bk_rtc_wr, bk_addr, bk_data,
    output sv_valid, sv_data, sv_done,
    output sv_skipped, busy
  );

  modport master (
    output ld_start, ld_abort, ld_valid, ld_data,
    output sv_req, rtc_inuse, rtc_timestamp,
    output rtc_savedtime, sv_ready,
    input  ld_ready, ld_done, ld_error,
    input  bk_rtc_wr, bk_addr, bk_data,
    input  sv_valid, sv_data, sv_done,
    input  sv_skipped, busy
  );
endinterface

// File: rtl/rtc_save_sequencer.sv
// Moves MBC3 RTC state between the 5-word save stream and the mapper.
// Ports: clk_sys, reset_n (async low), bus (load/mapper/save signals).
module rtc_save_sequencer #(
  parameter logic [15:0] MAGIC     = 16'h5254,
  parameter int          TIMEOUT_W = 20
) (
  input logic clk_sys,
  input logic reset_n,
  rtc_save_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COMMIT = 3'd2,
    S_SAVE   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0]   tmo_inc;
  logic [63:0]            snap_q, snap_d;
  logic                   err_q, err_d;
  logic                   is_ld_q, is_ld_d;
  logic                   skip_q, skip_d;
  logic                   bk_wr_q, bk_wr_d;
  logic [2:0]             bk_addr_q, bk_addr_d;
  logic [15:0]            bk_data_q, bk_data_d;
  logic                   unused_hi;

  // Only the low 32 bits of savedtime go into the file.
  assign unused_hi = ^bus.rtc_savedtime[47:32];
  assign tmo_inc   = tmo_q + TIMEOUT_W'(1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      snap_q    <= '0;
      err_q     <= 1'b0;
      is_ld_q   <= 1'b0;
      skip_q    <= 1'b0;
      bk_wr_q   <= 1'b0;
      bk_addr_q <= '0;
      bk_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      snap_q    <= snap_d;
      err_q     <= err_d;
      is_ld_q   <= is_ld_d;
      skip_q    <= skip_d;
      bk_wr_q   <= bk_wr_d;
      bk_addr_q <= bk_addr_d;
      bk_data_q <= bk_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    snap_d    = snap_q;
    err_d     = err_q;
    is_ld_d   = is_ld_q;
    skip_d    = skip_q;
    bk_wr_d   = 1'b0;
    bk_addr_d = bk_addr_q;
    bk_data_d = bk_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ld_start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          is_ld_d = 1'b1;
          skip_d  = 1'b0;
        end else if (bus.sv_req) begin
          idx_d   = '0;
          is_ld_d = 1'b0;
          if (bus.rtc_inuse) begin
            // Snapshot taken on the accepting edge.
            state_d = S_SAVE;
            skip_d  = 1'b0;
            snap_d  = {bus.rtc_savedtime[31:0],
                       bus.rtc_timestamp};
          end else begin
            state_d = S_DONE;
            skip_d  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bus.ld_abort) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (bus.ld_valid) begin
          tmo_d = '0;
          if (idx_q == 3'd4) begin
            if (bus.ld_data == MAGIC) begin
              // Commit strobe lands in the COMMIT cycle.
              state_d   = S_COMMIT;
              bk_wr_d   = 1'b1;
              bk_addr_d = 3'd4;
              bk_data_d = '0;
            end else begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            bk_wr_d   = 1'b1;
            bk_addr_d = idx_q;
            bk_data_d = bus.ld_data;
            idx_d     = idx_q + 3'd1;
          end
        end else begin
          tmo_d = tmo_inc;
          if (&tmo_inc) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_COMMIT: state_d = S_DONE;
      S_SAVE: begin
        if (bus.sv_ready) begin
          if (idx_q == 3'd4) state_d = S_DONE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ld_ready   = (state_q == S_LOAD);
    bus.sv_valid   = (state_q == S_SAVE);
    bus.busy       = (state_q != S_IDLE);
    bus.ld_done    = (state_q == S_DONE) && is_ld_q;
    bus.sv_done    = (state_q == S_DONE) && !is_ld_q;
    bus.sv_skipped = (state_q == S_DONE) && !is_ld_q
                     && skip_q;
    bus.ld_error   = err_q;
    bus.bk_rtc_wr  = bk_wr_q;
    bus.bk_addr    = {14'd0, bk_addr_q};
    bus.bk_data    = bk_data_q;
    unique case (idx_q)
      3'd0:    bus.sv_data = snap_q[15:0];
      3'd1:    bus.sv_data = snap_q[31:16];
      3'd2:    bus.sv_data = snap_q[47:32];
      3'd3:    bus.sv_data = snap_q[63:48];
      default: bus.sv_data = MAGIC;
    endcase
  end

endmodule

// File: tb/tb_rtc_save_sequencer.sv
// Directed bench for rtc_save_sequencer.
// Vector table for load paths, hand sequences for save/abort/timeout/reset.
module tb_rtc_save_sequencer;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   commits = 0;

  rtc_save_sequencer_if bus ();

  rtc_save_sequencer #(
    .MAGIC     (16'h5254),
    .TIMEOUT_W (4)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys)
    if (bus.bk_rtc_wr && bus.bk_addr == 17'd4)
      commits++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        st;
    logic        vl;
    logic [15:0] d;
    logic        wr;
    logic [2:0]  ad;
    logic [15:0] bd;
    logic        dn;
    logic        er;
    logic        by;
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  logic [15:0] exp_w[5];
  logic [36:0] act_v, exp_v;
  int          w;

  initial begin
    // good load
    tbl[0]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1};
    tbl[1]  = '{0, 1, 16'h1234, 1, 0, 16'h1234, 0, 0, 1};
    tbl[2]  = '{0, 1, 16'h5678, 1, 1, 16'h5678, 0, 0, 1};
    tbl[3]  = '{0, 1, 16'h0005, 1, 2, 16'h0005, 0, 0, 1};
    tbl[4]  = '{0, 1, 16'h0A00, 1, 3, 16'h0A00, 0, 0, 1};
    tbl[5]  = '{0, 1, 16'h5254, 1, 4, 16'h0000, 0, 0, 1};
    tbl[6]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 1};
    tbl[7]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0};
    // bad magic
    tbl[8]  = '{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1};
    tbl[9]  = '{0, 1, 16'h1234, 1, 0, 16'h1234, 0, 0, 1};
    tbl[10] = '{0, 1, 16'h5678, 1, 1, 16'h5678, 0, 0, 1};
    tbl[11] = '{0, 1, 16'h0005, 1, 2, 16'h0005, 0, 0, 1};
    tbl[12] = '{0, 1, 16'h0A00, 1, 3, 16'h0A00, 0, 0, 1};
    tbl[13] = '{0, 1, 16'hFFFF, 0, 0, 16'h0000, 1, 1, 1};
    tbl[14] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0};
    tbl[15] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0};

    exp_w[0] = 16'h0001;
    exp_w[1] = 16'h6000;
    exp_w[2] = 16'hDEF0;
    exp_w[3] = 16'h1ABC;
    exp_w[4] = 16'h5254;

    bus.ld_start      = 1'b0;
    bus.ld_abort      = 1'b0;
    bus.ld_valid      = 1'b0;
    bus.ld_data       = '0;
    bus.sv_req        = 1'b0;
    bus.rtc_inuse     = 1'b0;
    bus.rtc_timestamp = '0;
    bus.rtc_savedtime = '0;
    bus.sv_ready      = 1'b0;

    repeat (3) tick();
    reset_n = 1'b1;
    chk("reset_outputs",
        {bus.ld_ready, bus.ld_done, bus.ld_error,
         bus.bk_rtc_wr, bus.bk_addr, bus.bk_data,
         bus.sv_valid, bus.sv_done, bus.sv_skipped,
         bus.busy},
        '0);

    // load table
    for (int i = 0; i < 16; i++) begin
      bus.ld_start = tbl[i].st;
      bus.ld_valid = tbl[i].vl;
      bus.ld_data  = tbl[i].d;
      tick();
      bus.ld_start = 1'b0;
      bus.ld_valid = 1'b0;
      // addr/data only matter while the strobe is up
      act_v = {bus.bk_rtc_wr, bus.bk_addr[16:3],
               tbl[i].wr ? bus.bk_addr[2:0] : 3'd0,
               tbl[i].wr ? bus.bk_data : 16'd0,
               bus.ld_done, bus.ld_error, bus.busy};
      exp_v = {tbl[i].wr, 14'd0, tbl[i].ad, tbl[i].bd,
               tbl[i].dn, tbl[i].er, tbl[i].by};
      chk($sformatf("load_vec%0d", i), act_v, exp_v);
    end
    chk("commit_count_load", commits, 1);

    // save with toggling ready and snapshot atomicity
    bus.rtc_timestamp = 32'h6000_0001;
    bus.rtc_savedtime = 48'hFFFF_1ABC_DEF0;
    bus.rtc_inuse     = 1'b1;
    bus.sv_req        = 1'b1;
    tick();
    bus.sv_req        = 1'b0;
    bus.rtc_timestamp = 32'h0;
    bus.rtc_savedtime = 48'h0;
    w = 0;
    for (int c = 0; c < 20 && w < 5; c++) begin
      bus.sv_ready = (c % 2 == 0);
      chk($sformatf("sv_valid_c%0d", c), bus.sv_valid, 1);
      chk($sformatf("sv_word%0d_c%0d", w, c),
          bus.sv_data, exp_w[w]);
      chk($sformatf("sv_no_done_c%0d", c), bus.sv_done, 0);
      if (bus.sv_ready) w++;
      tick();
    end
    bus.sv_ready = 1'b0;
    chk("sv_all_words", w, 5);
    chk("sv_done_pulse",
        {bus.sv_done, bus.sv_skipped, bus.sv_valid,
         bus.ld_done},
        4'b1000);
    tick();
    chk("sv_done_once", {bus.sv_done, bus.busy}, 2'b00);

    // skip when RTC unused
    bus.rtc_inuse = 1'b0;
    bus.sv_req    = 1'b1;
    tick();
    bus.sv_req    = 1'b0;
    chk("skip_done",
        {bus.sv_done, bus.sv_skipped, bus.sv_valid},
        3'b110);
    tick();
    chk("skip_idle", {bus.sv_done, bus.busy}, 2'b00);

    // load beats save; then abort after two words
    bus.rtc_inuse     = 1'b1;
    bus.rtc_timestamp = 32'h1111_2222;
    bus.ld_start      = 1'b1;
    bus.sv_req        = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    bus.sv_req   = 1'b0;
    chk("conflict_load_wins",
        {bus.ld_ready, bus.sv_valid, bus.ld_error},
        3'b100);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hAAAA;
    tick();
    bus.ld_data  = 16'hBBBB;
    tick();
    chk("abort_w1",
        {bus.bk_rtc_wr, bus.bk_addr, bus.bk_data},
        {1'b1, 17'd1, 16'hBBBB});
    bus.ld_valid = 1'b0;
    bus.ld_abort = 1'b1;
    tick();
    bus.ld_abort = 1'b0;
    chk("abort_done",
        {bus.ld_done, bus.ld_error, bus.bk_rtc_wr,
         bus.sv_done},
        4'b1100);
    tick();
    chk("abort_idle", {bus.busy, bus.ld_error}, 2'b01);
    chk("commit_count_abort", commits, 1);

    // idle timeout with TIMEOUT_W=4
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("tmo_err_cleared", bus.ld_error, 0);
    repeat (14) tick();
    chk("tmo_still_load",
        {bus.ld_ready, bus.ld_done}, 2'b10);
    tick();
    chk("tmo_done",
        {bus.ld_done, bus.ld_error, bus.ld_ready},
        3'b110);
    tick();
    chk("tmo_idle", bus.busy, 0);
    chk("commit_count_tmo", commits, 1);

    // reset in the middle of a save
    bus.rtc_inuse = 1'b1;
    bus.sv_req    = 1'b1;
    tick();
    bus.sv_req    = 1'b0;
    tick();
    chk("rst_pre_valid", bus.sv_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async",
        {bus.sv_valid, bus.busy, bus.bk_rtc_wr,
         bus.ld_error},
        4'b0000);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_idle",
        {bus.sv_valid, bus.busy, bus.sv_done,
         bus.bk_rtc_wr},
        4'b0000);
    chk("commit_count_end", commits, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
